// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared instruction field positions and fetch FSM encoding
package cpu_pkg;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int IMM_MSB = 6;
  localparam int IMM_LSB = 0;
  localparam int JT_MSB  = 12;
  localparam int JT_LSB  = 0;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  function automatic logic [15:0] sext_imm(input logic [IMM_MSB:IMM_LSB] imm);
    return {{(15 - IMM_MSB){imm[IMM_MSB]}}, imm};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC select: jump, taken branch or sequential
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [15:0]          pc_out,
  input  logic [JT_MSB:JT_LSB] field,
  input  logic                 jump,
  input  logic                 branch,
  input  logic                 zero,
  output logic [15:0]          next_pc
);

  logic [15:0] pc1;

  assign pc1 = pc_out + 16'd1;

  // jump keeps the page bits of the sequential PC and replaces the rest
  assign next_pc = jump             ? {pc1[15:JT_MSB+1], field} :
                   (branch && zero) ? pc1 + sext_imm(field[IMM_MSB:IMM_LSB]) :
                                      pc1;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - two-state instruction fetch with redirect; FETCH_PERF_CNT_EN adds retired_cnt
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          OPCODE_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [15:0]         imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_rdata,
  output logic [15:0]         instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [15:0]         pc_out,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                jump,
  input  logic                branch,
  input  logic                zero
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]         retired_cnt
`endif
);

  fetch_state_t state;
  logic [15:0]  pc;
  logic [15:0]  next_pc;

  assign imem_addr = pc;
  assign opcode    = instr[OPC_MSB -: OPCODE_W];

  next_pc_calc u_next_pc_calc (
    .pc_out  (pc_out),
    .field   (instr[JT_MSB:JT_LSB]),
    .jump    (jump),
    .branch  (branch),
    .zero    (zero),
    .next_pc (next_pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= 16'h0000;
      pc_out      <= 16'h0000;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          // request comes up one edge after reset release; acks before that are ignored
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            instr       <= imem_rdata;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_cnt <= 16'h0000;
    end else if (instr_valid && instr_ready) begin
      retired_cnt <= retired_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed checks of fetch_unit against a behavioural model
module tb_fetch_unit;

  localparam logic [15:0] RST = 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] instr;
  logic [2:0]  opcode;
  logic [15:0] pc_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] retired_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int vcnt = 0;

  // model state: requesting, holding, fetch address, held word and its address
  logic        m_req;
  logic        m_valid;
  logic [15:0] m_pc;
  logic [15:0] m_instr;
  logic [15:0] m_pcout;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] m_cnt;
`endif

  fetch_unit #(.RESET_PC(RST), .OPCODE_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .pc_out      (pc_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump        (jump),
    .branch      (branch),
    .zero        (zero)
`ifdef FETCH_PERF_CNT_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_next(input logic [15:0] pco, input logic [15:0] ins,
                                             input logic j, input logic b, input logic z);
    int pc1;
    int off;
    pc1 = (int'(pco) + 1) % 65536;
    off = int'(ins & 16'h007F);
    if (off >= 64) off = off - 128;
    if (j) return 16'((pc1 & 32'hE000) | int'(ins & 16'h1FFF));
    if (b && z) return 16'((pc1 + off + 65536) % 65536);
    return 16'(pc1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_req   <= 1'b0;
      m_valid <= 1'b0;
      m_pc    <= RST;
      m_instr <= 16'h0000;
      m_pcout <= 16'h0000;
`ifdef FETCH_PERF_CNT_EN
      m_cnt   <= 16'h0000;
`endif
    end else if (!m_valid) begin
      if (!m_req) begin
        m_req <= 1'b1;
      end else if (imem_ack) begin
        m_instr <= imem_rdata;
        m_pcout <= m_pc;
        m_valid <= 1'b1;
        m_req   <= 1'b0;
      end
    end else if (instr_ready) begin
      m_pc    <= model_next(m_pcout, m_instr, jump, branch, zero);
      m_valid <= 1'b0;
      m_req   <= 1'b1;
`ifdef FETCH_PERF_CNT_EN
      m_cnt   <= m_cnt + 16'd1;
`endif
    end
  end

  always @(negedge clk) begin
    chk("imem_req", 32'(imem_req), 32'(m_req));
    if (m_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("instr", 32'(instr), 32'(m_instr));
    chk("opcode", 32'(opcode), 32'(m_instr[15:13]));
    chk("pc_out", 32'(pc_out), 32'(m_pcout));
`ifdef FETCH_PERF_CNT_EN
    chk("retired_cnt", 32'(retired_cnt), 32'(m_cnt));
`endif
    if (instr_valid) vcnt++;
  end

  task automatic run_instr(input logic [15:0] rd, input int ack_dly, input int rdy_dly,
                           input bit spur, input logic j, input logic b, input logic z);
    int n;
    n = 0;
    while (!m_req && n < 20) begin
      step;
      n++;
    end
    if (!m_req) begin
      chk("fetch_timeout", 32'(m_req), 32'd1);
      return;
    end
    repeat (ack_dly) begin
      imem_ack   = 1'b0;
      imem_rdata = 16'($urandom);
      step;
    end
    imem_ack   = 1'b1;
    imem_rdata = rd;
    step;
    imem_ack = 1'b0;
    repeat (rdy_dly) begin
      instr_ready = 1'b0;
      imem_ack    = spur ? 1'($urandom) : 1'b0;
      imem_rdata  = 16'($urandom);
      jump        = 1'($urandom);
      branch      = 1'($urandom);
      zero        = 1'($urandom);
      step;
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    jump        = j;
    branch      = b;
    zero        = z;
    step;
    instr_ready = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    zero        = 1'b0;
  endtask

  initial begin
    longint t0;
    int     v0;
    logic [15:0] a;
    logic [15:0] pc1;

    #1 reset = 1'b0;
    step;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_pc_out", 32'(pc_out), 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'(RST));
    reset = 1'b1;
    step;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", 32'(imem_addr), 32'h0000);

    // zero-wait sequential stream
    t0 = $time;
    v0 = vcnt;
    for (int k = 0; k < 4; k++) begin
      chk("seq_addr", 32'(imem_addr), 32'(k));
      run_instr(16'h2000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("seq_cycles", 32'(($time - t0) / 10), 32'd8);
    chk("seq_valid_pulses", 32'(vcnt - v0), 32'd4);

    run_instr(16'h0010, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("jump_0010", 32'(imem_addr), 32'h0010);
    run_instr(16'h007E, 0, 1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("branch_taken", 32'(imem_addr), 32'h000F);
    run_instr(16'h0010, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_instr(16'h007E, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("branch_not_taken", 32'(imem_addr), 32'h0011);
    run_instr(16'h0040, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("branch_neg_wrap", 32'(imem_addr), 32'hFFD2);
    run_instr(16'h1FFF, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("jump_ffff", 32'(imem_addr), 32'hFFFF);

    // delayed ack holds the request
    repeat (3) begin
      imem_ack = 1'b0;
      step;
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", 32'(imem_addr), 32'hFFFF);
      chk("wait_valid", 32'(instr_valid), 32'd0);
    end
    run_instr(16'h4000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_0000", 32'(imem_addr), 32'h0000);

    // long hold with spurious acks
    imem_ack   = 1'b1;
    imem_rdata = 16'h6ABC;
    step;
    for (int k = 0; k < 5; k++) begin
      instr_ready = 1'b0;
      imem_ack    = k[0] ? 1'b0 : 1'b1;
      imem_rdata  = 16'hFFFF;
      step;
      chk("hold_instr", 32'(instr), 32'h6ABC);
      chk("hold_req", 32'(imem_req), 32'd0);
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    step;
    instr_ready = 1'b0;
    chk("after_hold", 32'(imem_addr), 32'h0001);

    // walk backwards through the address space to 0xA004
    a = m_pc;
    for (int n = 0; n < 400 && a != 16'hA004; n++) begin
      pc1 = a + 16'd1;
      if (pc1[15:13] == 3'b101) run_instr(16'h0004, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      else run_instr(16'h0040, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
      a = m_pc;
    end
    chk("steer_reached", 32'(a), 32'hA004);
    run_instr(16'h2123, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("jump_over_branch", 32'(imem_addr), 32'hA123);

    for (int k = 0; k < 80; k++) begin
      run_instr(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1,
                1'($urandom), 1'($urandom), 1'($urandom));
    end

    // reset in the middle of a fetch
    imem_ack = 1'b0;
    step;
    imem_ack = 1'b1;
    reset    = 1'b0;
    #1;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_addr", 32'(imem_addr), 32'(RST));
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    step;
    imem_ack = 1'b0;
    reset    = 1'b1;
    step;
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", 32'(imem_addr), 32'(RST));
    for (int k = 0; k < 4; k++) begin
      run_instr(16'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0,
                1'b0, 1'($urandom), 1'($urandom));
    end
`ifdef FETCH_PERF_CNT_EN
    chk("retired_4", 32'(retired_cnt), 32'd4);
`endif
    chk("restart_seq", 32'(imem_addr), 32'(m_pc));
    step;
    step;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
